// File: rtl/rf_writeback_pkg.sv
// Shared definitions for the register-file writeback slice.
// Contents:
//   AddrWidth / DataWidth  default register index and data widths
//   ZeroReg                index of the hardwired-zero register
//   wb_req_t               writeback request (valid, rd, data) at default widths
package rf_writeback_pkg;

  localparam int unsigned AddrWidth = 5;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned ZeroReg   = 0;

  typedef struct packed {
    logic                 valid;
    logic [AddrWidth-1:0] rd;
    logic [DataWidth-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_writeback_if.sv
// Writeback result channels from execute (ALU) and load/store (LSU) into rf_writeback.
// Signals:
//   a_valid/a_rd/a_data  ALU result; accepted the same cycle unless a_hold
//   a_hold               ALU must not present a result this cycle
//   m_valid/m_rd/m_data  LSU result; accepted when m_valid && m_ready
//   m_ready              LSU result accepted this cycle
// master = result producers, slave = the writeback controller.
interface rf_writeback_if
  import rf_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned DATA_WIDTH = DataWidth
) ();

  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_rd;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_hold;

  logic                  m_valid;
  logic [ADDR_WIDTH-1:0] m_rd;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    input  a_hold, m_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    output a_hold, m_ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears all busy bits)
//   set_valid, set_rd     issue of an instruction writing set_rd (rd 0 ignored)
//   clr_valid, clr_rd     RF write this cycle, retires clr_rd
//   raddr1, raddr2        decode read addresses
//   hazard1, hazard2      operand still pending on the respective read port
module rf_scoreboard
  import rf_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_rd,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  hazard1,
  output logic                  hazard2
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0] busy_q, busy_d;

  // Set is applied after clear so a re-issue to the register being written stays busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_rd] = 1'b0;
    if (set_valid) busy_d[set_rd] = 1'b1;
    busy_d[ZeroReg] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A write landing this cycle resolves the operand: the bypass supplies it next cycle.
  always_comb begin
    hazard1 = busy_q[raddr1] && !(clr_valid && (clr_rd == raddr1));
    hazard2 = busy_q[raddr2] && !(clr_valid && (clr_rd == raddr2));
  end

endmodule

// File: rtl/rf_writeback.sv
// Write-side controller for the integer register file.
// Arbitrates ALU and LSU results onto the single RF write port (ALU preferred, LSU
// protected from starvation), tracks in-flight destinations in rf_scoreboard and
// bypasses same-edge writes around the RF's registered read.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb                       ALU/LSU result channels (slave side)
//   iss_valid, iss_rd        issued instruction destination
//   raddr1, raddr2           decode read addresses (also driven to the RF)
//   rf_rdata1, rf_rdata2     raw RF read data, one cycle after the address
//   wen, waddr, wdata        RF write port
//   rdata1, rdata2           bypassed read data, same timing as rf_rdata*
//   hazard                   an operand of raddr1/raddr2 is still pending
//   err                      sticky: ALU presented a result while held off
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_writeback_if.slave         wb,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  hazard,
  output logic                  err
);

  localparam int unsigned           CntWidth = $clog2(STARVE_MAX + 1);
  localparam logic [CntWidth-1:0]   CntMax   = CntWidth'(STARVE_MAX);
  localparam logic [ADDR_WIDTH-1:0] RegZero  = ADDR_WIDTH'(ZeroReg);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } win_t;

  logic [CntWidth-1:0]   starve_q, starve_d;
  logic                  err_q;
  logic                  a_hold_c, m_ready_c, alu_win, m_acc;
  win_t                  win;

  logic [ADDR_WIDTH-1:0] raddr1_q, raddr2_q, waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wen_q;
  logic                  hazard1, hazard2;

  // Arbitration: ALU wins unless held off, in which case the LSU is guaranteed a slot.
  always_comb begin
    a_hold_c  = (starve_q == CntMax);
    alu_win   = wb.a_valid && !a_hold_c;
    m_ready_c = !alu_win;
    m_acc     = wb.m_valid && m_ready_c;
    win       = '0;
    if (alu_win) begin
      win = '{valid: 1'b1, rd: wb.a_rd, data: wb.a_data};
    end else if (m_acc) begin
      win = '{valid: 1'b1, rd: wb.m_rd, data: wb.m_data};
    end
  end

  assign wb.a_hold  = a_hold_c;
  assign wb.m_ready = m_ready_c;

  // rd 0 results complete their handshake but never reach the RF.
  assign wen   = win.valid && (win.rd != RegZero) && !rst;
  assign waddr = win.rd;
  assign wdata = win.data;

  // Counts consecutive cycles the LSU is waiting; any accept or idle cycle restarts it.
  always_comb begin
    starve_d = '0;
    if (wb.m_valid && !m_ready_c) begin
      starve_d = (starve_q == CntMax) ? CntMax : starve_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      err_q    <= 1'b0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_q | (wb.a_valid && a_hold_c);
      raddr1_q <= raddr1;
      raddr2_q <= raddr2;
      wen_q    <= wen;
      waddr_q  <= waddr;
      wdata_q  <= wdata;
    end
  end

  assign err = err_q;

  // The RF returns the pre-write value when read and written on the same edge.
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    if (wen_q && (waddr_q == raddr1_q) && (raddr1_q != RegZero)) rdata1 = wdata_q;
    if (wen_q && (waddr_q == raddr2_q) && (raddr2_q != RegZero)) rdata2 = wdata_q;
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (iss_valid && (iss_rd != RegZero)),
    .set_rd    (iss_rd),
    .clr_valid (wen),
    .clr_rd    (waddr),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .hazard1   (hazard1),
    .hazard2   (hazard2)
  );

  assign hazard = hazard1 | hazard2;

endmodule
